// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32 load/store funct3 encodings and strobe width.
package rv32_pkg;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam int STRB_W = 4;
endpackage

// File: rtl/store_align.sv
// store_align: places store data into word lanes, builds byte strobes and
// flags misaligned or illegal stores.
module store_align
    import rv32_pkg::*;
(
    input  logic [1:0]        i_addr,
    input  logic [31:0]       i_data,
    input  logic [2:0]        i_funct3,
    output logic [31:0]       o_wdata,
    output logic [STRB_W-1:0] o_wstrb,
    output logic              o_misalign,
    output logic              o_illegal
);
    logic w_sb, w_sh, w_sw;
    always_comb begin
        w_sb       = i_funct3 == F3_SB;
        w_sh       = i_funct3 == F3_SH;
        w_sw       = i_funct3 == F3_SW;
        o_illegal  = !(w_sb || w_sh || w_sw);
        o_misalign = (w_sh && i_addr[0]) || (w_sw && i_addr != 2'b00);
        o_wdata    = w_sb ? {4{i_data[7:0]}} : w_sh ? {2{i_data[15:0]}} : i_data;
        o_wstrb    = w_sb ? 4'b0001 << i_addr : w_sh ? (i_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    end
endmodule

// File: rtl/store_unit.sv
// store_unit: buffers aligned stores in a small FIFO and issues them to data
// memory over valid/ready; faulting stores are consumed and reported instead.
module store_unit
    import rv32_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_data,
    input  logic [2:0]        StoreControl,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [STRB_W-1:0] mem_wstrb,
    output logic              store_misalign,
    output logic              store_illegal,
    output logic [31:0]       fault_addr,
    output logic              busy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [29:0]       r_addr  [DEPTH];
    logic [31:0]       r_wdata [DEPTH];
    logic [STRB_W-1:0] r_wstrb [DEPTH];
    logic [PW-1:0]     r_rd_ptr, r_wr_ptr;
    logic [CW-1:0]     r_count;
    logic              r_misalign, r_illegal;
    logic [31:0]       r_fault_addr;

    logic [31:0]       w_wdata;
    logic [STRB_W-1:0] w_wstrb;
    logic              w_misalign, w_illegal, w_accept, w_push, w_pop;

    store_align u_align (
        .i_addr     (req_addr[1:0]),
        .i_data     (req_data),
        .i_funct3   (StoreControl),
        .o_wdata    (w_wdata),
        .o_wstrb    (w_wstrb),
        .o_misalign (w_misalign),
        .o_illegal  (w_illegal)
    );

    assign req_ready      = r_count != CW'(DEPTH);
    assign w_accept       = req_valid && req_ready;
    assign w_push         = w_accept && !w_misalign && !w_illegal;
    assign mem_valid      = r_count != '0;
    assign w_pop          = mem_valid && mem_ready;
    assign busy           = mem_valid;
    assign mem_addr       = {r_addr[r_rd_ptr], 2'b00};
    assign mem_wdata      = r_wdata[r_rd_ptr];
    assign mem_wstrb      = r_wstrb[r_rd_ptr];
    assign store_misalign = r_misalign;
    assign store_illegal  = r_illegal;
    assign fault_addr     = r_fault_addr;

    // Storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wr_ptr]  <= req_addr[31:2];
            r_wdata[r_wr_ptr] <= w_wdata;
            r_wstrb[r_wr_ptr] <= w_wstrb;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_misalign   <= 1'b0;
            r_illegal    <= 1'b0;
            r_fault_addr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count    <= r_count + CW'(w_push) - CW'(w_pop);
            r_misalign <= w_accept && w_misalign && !w_illegal;
            r_illegal  <= w_accept && w_illegal;
            if (w_accept && (w_misalign || w_illegal)) r_fault_addr <= req_addr;
        end
    end
endmodule

// File: tb/tb_store_unit.sv
// tb_store_unit: directed stimulus against a queue-based store-buffer model,
// checked every cycle plus hand-computed literal expectations.
module tb_store_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic [2:0]  StoreControl = '0;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr, mem_wdata, fault_addr;
    logic [3:0]  mem_wstrb;
    logic        store_misalign, store_illegal, busy;

    int n_tests = 0;
    int n_fail = 0;
    bit run = 0;

    store_unit #(.DEPTH(2)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .StoreControl(StoreControl),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .store_misalign(store_misalign),
        .store_illegal(store_illegal), .fault_addr(fault_addr), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } wr_t;

    wr_t         q[$];
    logic        m_mis = 0, m_ill = 0;
    logic [31:0] m_fa = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: encode from the architectural rules, then track the buffer as a queue.
    always @(posedge clk) begin
        wr_t e;
        bit  mis, ill, pop, acc;
        if (reset) begin
            q.delete();
            m_mis = 0;
            m_ill = 0;
            m_fa  = 0;
        end else begin
            mis = 0;
            ill = 0;
            e.addr = req_addr - (req_addr % 4);
            case (StoreControl)
                3'd0: begin e.wdata = (req_data & 32'hFF) * 32'h01010101;   e.wstrb = 4'(1 << (req_addr % 4)); end
                3'd1: begin e.wdata = (req_data & 32'hFFFF) * 32'h00010001; e.wstrb = 4'(3 << (req_addr & 2)); mis = (req_addr % 2) != 0; end
                3'd2: begin e.wdata = req_data; e.wstrb = 4'hF; mis = (req_addr % 4) != 0; end
                default: begin e.wdata = 0; e.wstrb = 0; ill = 1; end
            endcase
            if (ill) mis = 0;
            pop = q.size() > 0 && mem_ready;
            acc = req_valid && q.size() < 2;
            m_mis = acc && mis;
            m_ill = acc && ill;
            if (acc && (mis || ill)) m_fa = req_addr;
            if (pop) void'(q.pop_front());
            if (acc && !mis && !ill) q.push_back(e);
        end
    end

    always @(negedge clk) begin
        if (run) begin
            chk("mem_valid", 32'(mem_valid), 32'(q.size() != 0));
            chk("busy", 32'(busy), 32'(q.size() != 0));
            chk("req_ready", 32'(req_ready), 32'(q.size() < 2));
            chk("store_misalign", 32'(store_misalign), 32'(m_mis));
            chk("store_illegal", 32'(store_illegal), 32'(m_ill));
            chk("fault_addr", fault_addr, m_fa);
            if (q.size() != 0) begin
                chk("mem_addr", mem_addr, q[0].addr);
                chk("mem_wdata", mem_wdata, q[0].wdata);
                chk("mem_wstrb", 32'(mem_wstrb), 32'(q[0].wstrb));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
        req_valid    = 1'b1;
        req_addr     = a;
        req_data     = d;
        StoreControl = f;
    endtask

    initial begin
        logic [3:0] strb_tab [4];
        strb_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        step();
        run = 1;
        step();
        reset = 1'b0;
        chk("rst req_ready", 32'(req_ready), 32'd1);
        chk("rst mem_valid", 32'(mem_valid), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst fault_addr", fault_addr, 32'd0);

        req(32'h103, 32'hAABBCCDD, 3'b000);
        step();
        req_valid = 1'b0;
        chk("sb mem_valid", 32'(mem_valid), 32'd1);
        chk("sb mem_addr", mem_addr, 32'h100);
        chk("sb mem_wdata", mem_wdata, 32'hDDDDDDDD);
        chk("sb mem_wstrb", 32'(mem_wstrb), 32'b1000);
        mem_ready = 1'b1;
        step();
        chk("sb busy after pop", 32'(busy), 32'd0);

        req(32'h202, 32'h1234ABCD, 3'b001);
        step();
        req_valid = 1'b0;
        chk("sh mem_wdata", mem_wdata, 32'hABCDABCD);
        chk("sh mem_wstrb", 32'(mem_wstrb), 32'b1100);
        chk("sh busy", 32'(busy), 32'd1);
        step();
        chk("sh busy falls", 32'(busy), 32'd0);

        req(32'h301, 32'h55555555, 3'b010);
        step();
        req_valid = 1'b0;
        chk("sw misalign", 32'(store_misalign), 32'd1);
        chk("sw fault_addr", fault_addr, 32'h301);
        chk("sw no issue", 32'(mem_valid), 32'd0);
        step();
        chk("misalign pulse ends", 32'(store_misalign), 32'd0);
        chk("fault_addr held", fault_addr, 32'h301);

        req(32'h304, 32'h0, 3'b011);
        step();
        chk("illegal flag", 32'(store_illegal), 32'd1);
        chk("illegal not misalign", 32'(store_misalign), 32'd0);
        chk("illegal fault_addr", fault_addr, 32'h304);
        req(32'h305, 32'h0, 3'b111);
        step();
        req_valid = 1'b0;
        chk("illegal precedence", 32'(store_misalign), 32'd0);
        chk("illegal nothing issued", 32'(mem_valid), 32'd0);

        req(32'h201, 32'h0, 3'b001);
        step();
        chk("sh odd misalign", 32'(store_misalign), 32'd1);
        req(32'h200, 32'h0000BEEF, 3'b001);
        step();
        req_valid = 1'b0;
        chk("sh low strb", 32'(mem_wstrb), 32'b0011);
        chk("sh low wdata", mem_wdata, 32'hBEEFBEEF);
        step();

        for (int i = 0; i < 4; i++) begin
            req(32'h600 + 32'(i), 32'h000000A0 + 32'(i), 3'b000);
            step();
            chk("sb lane strb", 32'(mem_wstrb), 32'(strb_tab[i]));
        end
        req_valid = 1'b0;
        step();

        mem_ready = 1'b0;
        req(32'h400, 32'h11111111, 3'b010);
        step();
        req(32'h404, 32'h22222222, 3'b010);
        step();
        chk("full req_ready", 32'(req_ready), 32'd0);
        req(32'h408, 32'h33333333, 3'b010);
        step();
        step();
        chk("stall wdata held", mem_wdata, 32'h11111111);
        mem_ready = 1'b1;
        step();
        chk("second in order", mem_wdata, 32'h22222222);
        chk("slot frees req_ready", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        chk("third issued", mem_wdata, 32'h33333333);
        step();
        chk("drained", 32'(mem_valid), 32'd0);

        mem_ready = 1'b0;
        req(32'h500, 32'h77777777, 3'b010);
        step();
        mem_ready = 1'b1;
        req(32'h50C, 32'h0, 3'b011);
        step();
        req_valid = 1'b0;
        chk("fault with pop empties", 32'(mem_valid), 32'd0);
        chk("fault with pop flag", 32'(store_illegal), 32'd1);

        mem_ready = 1'b0;
        req(32'h700, 32'h88888888, 3'b010);
        step();
        req(32'h704, 32'h99999999, 3'b010);
        step();
        req(32'h709, 32'h0, 3'b110);
        reset = 1'b1;
        mem_ready = 1'b1;
        step();
        reset = 1'b0;
        req_valid = 1'b0;
        chk("reset mem_valid", 32'(mem_valid), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset clears fault", 32'(store_illegal), 32'd0);
        chk("reset fault_addr", fault_addr, 32'd0);
        repeat (3) step();
        chk("no writes after reset", 32'(mem_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
